// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate left/right, bounce and fill/drain on a WIDTH-bit bank,
// stepping once per DIV clock cycles.
module led_pattern_gen #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 25000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             pause,
   output logic [WIDTH-1:0] led,
   output logic             tick
);

   localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CntMax  = CNT_W'(DIV - 1);
   localparam logic [WIDTH-1:0] LedInit = WIDTH'(1);

   typedef enum logic {DirLeft, DirRight} dir_e;
   typedef enum logic {PhFill, PhDrain} phase_e;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] led_q, led_d, led_nxt;
   logic             tick_q, tick_d;
   logic [1:0]       mode_q, mode_d;
   dir_e             dir_q, dir_d, dir_nxt;
   phase_e           phase_q, phase_d, phase_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         led_q   <= LedInit;
         tick_q  <= 1'b0;
         mode_q  <= mode;
         dir_q   <= DirLeft;
         phase_q <= PhFill;
      end else begin
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         tick_q  <= tick_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         phase_q <= phase_d;
      end
   end

   // Pattern successor of the current led value for the latched mode
   always_comb begin
      led_nxt   = led_q;
      dir_nxt   = dir_q;
      phase_nxt = phase_q;
      unique case (mode_q)
         2'b00: led_nxt = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
         2'b01: led_nxt = {led_q[0], led_q[WIDTH-1:1]};
         2'b10: begin
            if (dir_q == DirLeft) begin
               led_nxt = {led_q[WIDTH-2:0], 1'b0};
               if (led_nxt[WIDTH-1]) dir_nxt = DirRight;
            end else begin
               led_nxt = {1'b0, led_q[WIDTH-1:1]};
               if (led_nxt[0]) dir_nxt = DirLeft;
            end
         end
         2'b11: begin
            if (phase_q == PhFill) begin
               led_nxt = {led_q[WIDTH-2:0], 1'b1};
               if (&led_nxt) phase_nxt = PhDrain;
            end else begin
               led_nxt = {led_q[WIDTH-2:0], 1'b0};
               if (led_nxt == '0) phase_nxt = PhFill;
            end
         end
         default: led_nxt = led_q;
      endcase
   end

   // Next state: a mode change reloads and wins over both pause and a step
   always_comb begin
      cnt_d   = cnt_q;
      led_d   = led_q;
      tick_d  = 1'b0;
      mode_d  = mode_q;
      dir_d   = dir_q;
      phase_d = phase_q;
      if (mode != mode_q) begin
         mode_d  = mode;
         led_d   = LedInit;
         cnt_d   = '0;
         dir_d   = DirLeft;
         phase_d = PhFill;
      end else if (!pause) begin
         if (cnt_q == CntMax) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            led_d   = led_nxt;
            dir_d   = dir_nxt;
            phase_d = phase_nxt;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Outputs
   always_comb begin
      led  = led_q;
      tick = tick_q;
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen: four instances of different WIDTH/DIV checked
// every cycle against a step-index reference model, plus directed pattern sequences.
module tb_led_pattern_gen;

   localparam int NI = 4;
   localparam int W_P [NI] = '{8, 4, 5, 2};
   localparam int D_P [NI] = '{4, 1, 3, 1};

   logic       clk = 1'b0;
   logic       rst_v   [NI];
   logic [1:0] mode_v  [NI];
   logic       pause_v [NI];
   logic [7:0] led0;
   logic [3:0] led1;
   logic [4:0] led2;
   logic [1:0] led3;
   logic       tick0, tick1, tick2, tick3;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: mode, step index since reload, unpaused cycles in the current period
   int m_mode [NI];
   int m_k    [NI];
   int m_cyc  [NI];
   bit m_tick [NI];

   always #5 clk = ~clk;

   led_pattern_gen #(.WIDTH(8), .DIV(4)) u_dut0 (
      .clk(clk), .reset(rst_v[0]), .mode(mode_v[0]), .pause(pause_v[0]), .led(led0), .tick(tick0)
   );
   led_pattern_gen #(.WIDTH(4), .DIV(1)) u_dut1 (
      .clk(clk), .reset(rst_v[1]), .mode(mode_v[1]), .pause(pause_v[1]), .led(led1), .tick(tick1)
   );
   led_pattern_gen #(.WIDTH(5), .DIV(3)) u_dut2 (
      .clk(clk), .reset(rst_v[2]), .mode(mode_v[2]), .pause(pause_v[2]), .led(led2), .tick(tick2)
   );
   led_pattern_gen #(.WIDTH(2), .DIV(1)) u_dut3 (
      .clk(clk), .reset(rst_v[3]), .mode(mode_v[3]), .pause(pause_v[3]), .led(led3), .tick(tick3)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] dut_led(input int i);
      case (i)
         0:       return 16'(led0);
         1:       return 16'(led1);
         2:       return 16'(led2);
         default: return 16'(led3);
      endcase
   endfunction

   function automatic logic [15:0] dut_tick(input int i);
      case (i)
         0:       return 16'(tick0);
         1:       return 16'(tick1);
         2:       return 16'(tick2);
         default: return 16'(tick3);
      endcase
   endfunction

   // LED value k steps after a reload, straight from the pattern definitions
   function automatic logic [15:0] pattern(input int w, input int m, input int k);
      int p, pos, ones;
      ones = (1 << w) - 1;
      case (m)
         0: return 16'(1 << (k % w));
         1: return 16'(1 << ((w - (k % w)) % w));
         2: begin
            p   = k % (2 * w - 2);
            pos = (p < w) ? p : (2 * w - 2 - p);
            return 16'(1 << pos);
         end
         default: begin
            p = k % (2 * w);
            if (p < w) return 16'((1 << (p + 1)) - 1);
            return 16'((ones << (p - w + 1)) & ones);
         end
      endcase
   endfunction

   task automatic model_update(input int i);
      if (rst_v[i] || int'(mode_v[i]) != m_mode[i]) begin
         m_mode[i] = int'(mode_v[i]);
         m_k[i]    = 0;
         m_cyc[i]  = 0;
         m_tick[i] = 1'b0;
      end else if (!pause_v[i]) begin
         m_cyc[i]++;
         if (m_cyc[i] == D_P[i]) begin
            m_cyc[i]  = 0;
            m_k[i]++;
            m_tick[i] = 1'b1;
         end else begin
            m_tick[i] = 1'b0;
         end
      end else begin
         m_tick[i] = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int i = 0; i < NI; i++) model_update(i);
      #1;
      for (int i = 0; i < NI; i++) begin
         check_eq($sformatf("model_led%0d", i), dut_led(i), pattern(W_P[i], m_mode[i], m_k[i]));
         check_eq($sformatf("model_tick%0d", i), dut_tick(i), 16'(m_tick[i]));
      end
   endtask

   int bexp [9] = '{1, 2, 4, 8, 4, 2, 1, 2, 4};
   int fexp [9] = '{1, 3, 7, 15, 14, 12, 8, 0, 1};
   int rexp [3] = '{8'h80, 8'h40, 8'h20};

   initial begin
      int ticks, n8, n1;
      for (int i = 0; i < NI; i++) begin
         rst_v[i]   = 1'b1;
         pause_v[i] = 1'b0;
         m_mode[i]  = 0;
         m_k[i]     = 0;
         m_cyc[i]   = 0;
         m_tick[i]  = 1'b0;
      end
      mode_v[0] = 2'b00;
      mode_v[1] = 2'b10;
      mode_v[2] = 2'b11;
      mode_v[3] = 2'b10;

      // Reset, then rotate left on u_dut0 and bounce on u_dut1
      step();
      step();
      check_eq("reset_led0", 16'(led0), 16'h01);
      check_eq("reset_tick0", 16'(tick0), 16'h0);
      check_eq("bounce_seq0", 16'(led1), 16'(bexp[0]));
      for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
      ticks = 0;
      n8    = 0;
      n1    = 0;
      for (int j = 0; j < 32; j++) begin
         step();
         if (tick0) ticks++;
         if (j == 2) check_eq("rotl_before_step", 16'(led0), 16'h01);
         if (j == 3) begin
            check_eq("rotl_first_step", 16'(led0), 16'h02);
            check_eq("rotl_first_tick", 16'(tick0), 16'h1);
         end
         if (j == 4) check_eq("rotl_tick_pulse", 16'(tick0), 16'h0);
         if (j < 8) check_eq($sformatf("bounce_seq%0d", j + 1), 16'(led1), 16'(bexp[j + 1]));
         if (j < 6 && led1 == 4'h8) n8++;
         if (j < 6 && led1 == 4'h1) n1++;
      end
      check_eq("rotl_wrap", 16'(led0), 16'h01);
      check_eq("rotl_ticks", 16'(ticks), 16'd8);
      check_eq("bounce_top_once", 16'(n8), 16'd1);
      check_eq("bounce_bottom_once", 16'(n1), 16'd1);

      // Rotate right on u_dut0, fill/drain on u_dut1
      mode_v[0] = 2'b01;
      mode_v[1] = 2'b11;
      step();
      check_eq("rotr_reload", 16'(led0), 16'h01);
      check_eq("fill_seq0", 16'(led1), 16'(fexp[0]));
      for (int j = 1; j <= 12; j++) begin
         step();
         if (j <= 8) check_eq($sformatf("fill_seq%0d", j), 16'(led1), 16'(fexp[j]));
         if (j % 4 == 0) check_eq($sformatf("rotr_seq%0d", j / 4), 16'(led0), 16'(rexp[j / 4 - 1]));
      end

      // Pause then mode change while paused on u_dut0
      mode_v[0] = 2'b00;
      step();
      for (int j = 0; j < 10; j++) step();
      check_eq("pause_pre_led", 16'(led0), 16'h04);
      pause_v[0] = 1'b1;
      for (int j = 0; j < 10; j++) begin
         step();
         check_eq("pause_led", 16'(led0), 16'h04);
         check_eq("pause_tick", 16'(tick0), 16'h0);
      end
      mode_v[0] = 2'b10;
      step();
      check_eq("pause_reload", 16'(led0), 16'h01);
      pause_v[0] = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         step();
         if (j < 4) check_eq("resume_hold", 16'(led0), 16'h01);
      end
      check_eq("resume_step", 16'(led0), 16'h02);
      check_eq("resume_tick", 16'(tick0), 16'h1);

      // Reset mid fill at 0x3F with a partial prescaler count
      mode_v[0] = 2'b11;
      step();
      for (int j = 0; j < 22; j++) step();
      check_eq("fill_3f", 16'(led0), 16'h3F);
      rst_v[0] = 1'b1;
      step();
      check_eq("midreset_led", 16'(led0), 16'h01);
      check_eq("midreset_tick", 16'(tick0), 16'h0);
      rst_v[0] = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         step();
         if (j < 4) check_eq("midreset_hold", 16'(led0), 16'h01);
      end
      check_eq("midreset_step", 16'(led0), 16'h03);

      // Random mode, pause and reset traffic on all instances
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NI; i++) begin
            rst_v[i]   = ($urandom_range(0, 199) == 0);
            pause_v[i] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) mode_v[i] = 2'($urandom_range(0, 3));
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
